// File: rtl/multiplexer_pkg.sv
// Shared select-code constants for the bit-slice ALU result mux.
// Every ALU unit and bench takes the codes from here rather than literals.
package multiplexer_pkg;

  localparam int MUX_WIDTH = 3;

  localparam logic [MUX_WIDTH-1:0] AND_OUTPUT        = 3'b000;
  localparam logic [MUX_WIDTH-1:0] OR_OUTPUT         = 3'b001;
  localparam logic [MUX_WIDTH-1:0] XOR_OUTPUT        = 3'b010;
  localparam logic [MUX_WIDTH-1:0] ADDER_OUTPUT      = 3'b011;
  localparam logic [MUX_WIDTH-1:0] SUBTRACTOR_OUTPUT = 3'b100;

endpackage

// File: rtl/multiplexer.sv
// 5:1 single-bit ALU result selector with a registered copy
// and an illegal-select flag.
module multiplexer
  import multiplexer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 and_r_i,
  input  logic                 or_r_i,
  input  logic                 xor_r_i,
  input  logic                 adder_r_i,
  input  logic                 subtractor_r_i,
  input  logic [MUX_WIDTH-1:0] f_i,
  output logic                 result_o,
  output logic                 result_q_o,
  output logic                 sel_err_o
);

  logic w_result;
  logic w_sel_err;
  logic r_result_q;

  // X/Z or unused codes match no item and fall into default
  always_comb begin
    w_result  = 1'b0;
    w_sel_err = 1'b0;
    case (f_i)
      AND_OUTPUT:        w_result = and_r_i;
      OR_OUTPUT:         w_result = or_r_i;
      XOR_OUTPUT:        w_result = xor_r_i;
      ADDER_OUTPUT:      w_result = adder_r_i;
      SUBTRACTOR_OUTPUT: w_result = subtractor_r_i;
      default: begin
        w_result  = 1'b0;
        w_sel_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result_q <= 1'b0;
    end else begin
      r_result_q <= w_result;
    end
  end

  assign result_o   = w_result;
  assign sel_err_o  = w_sel_err;
  assign result_q_o = r_result_q;

endmodule

// File: tb/tb_multiplexer.sv
// Self-checking bench for the ALU result mux: directed scenarios
// followed by randomized traffic against a vector-indexing model.
module tb_multiplexer;
  import multiplexer_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 and_r_i;
  logic                 or_r_i;
  logic                 xor_r_i;
  logic                 adder_r_i;
  logic                 subtractor_r_i;
  logic [MUX_WIDTH-1:0] f_i;
  logic                 result_o;
  logic                 result_q_o;
  logic                 sel_err_o;

  int n_pass;
  int n_total;

  multiplexer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .and_r_i        (and_r_i),
    .or_r_i         (or_r_i),
    .xor_r_i        (xor_r_i),
    .adder_r_i      (adder_r_i),
    .subtractor_r_i (subtractor_r_i),
    .f_i            (f_i),
    .result_o       (result_o),
    .result_q_o     (result_q_o),
    .sel_err_o      (sel_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // d[0]=AND d[1]=OR d[2]=XOR d[3]=ADDER d[4]=SUBTRACTOR
  function automatic logic ref_result(logic [4:0] d, logic [2:0] f);
    if (int'(f) < 5) return d[int'(f)];
    return 1'b0;
  endfunction

  function automatic logic ref_err(logic [2:0] f);
    return int'(f) > 4;
  endfunction

  task automatic drive(input logic [4:0] d, input logic [2:0] f);
    and_r_i        = d[0];
    or_r_i         = d[1];
    xor_r_i        = d[2];
    adder_r_i      = d[3];
    subtractor_r_i = d[4];
    f_i            = f;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(5'b00000, 3'b000);
    n_total++;
    if (result_q_o !== 1'b0)
      $display("FAIL reset_q: got %b want 0", result_q_o);
    else n_pass++;
    n_total++;
    if (result_o !== 1'b0)
      $display("FAIL and_zero: got %b want 0", result_o);
    else n_pass++;
    drive(5'b00001, 3'b000);
    n_total++;
    if (result_o !== 1'b1 || sel_err_o !== 1'b0)
      $display("FAIL and_one: got %b/%b want 1/0",
               result_o, sel_err_o);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (result_q_o !== 1'b0)
      $display("FAIL reset_hold_q: got %b want 0", result_q_o);
    else n_pass++;
  endtask

  task automatic test_select_sweep();
    for (int s = 1; s < 5; s++) begin
      logic [4:0] d;
      d = '0;
      drive(d, 3'(s));
      n_total++;
      if (result_o !== 1'b0)
        $display("FAIL sweep%0d_lo: got %b want 0", s, result_o);
      else n_pass++;
      d[s] = 1'b1;
      drive(d, 3'(s));
      n_total++;
      if (result_o !== 1'b1 || sel_err_o !== 1'b0)
        $display("FAIL sweep%0d_hi: got %b/%b want 1/0",
                 s, result_o, sel_err_o);
      else n_pass++;
    end
  endtask

  task automatic test_isolation();
    drive(5'b10111, ADDER_OUTPUT);
    n_total++;
    if (result_o !== 1'b0)
      $display("FAIL iso_base: got %b want 0", result_o);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      logic [4:0] d;
      d = 5'($urandom);
      d[3] = 1'b0;
      drive(d, ADDER_OUTPUT);
      n_total++;
      if (result_o !== 1'b0)
        $display("FAIL iso_toggle d=%b: got %b want 0", d, result_o);
      else n_pass++;
    end
  endtask

  task automatic test_illegal();
    for (int c = 5; c < 8; c++) begin
      drive(5'b11111, 3'(c));
      n_total++;
      if (result_o !== 1'b0 || sel_err_o !== 1'b1)
        $display("FAIL illegal%0d: got %b/%b want 0/1",
                 c, result_o, sel_err_o);
      else n_pass++;
    end
    drive(5'b11111, 3'b000);
    n_total++;
    if (result_o !== 1'b1 || sel_err_o !== 1'b0)
      $display("FAIL illegal_back: got %b/%b want 1/0",
               result_o, sel_err_o);
    else n_pass++;
  endtask

  task automatic test_register();
    @(negedge clk);
    rst_n = 1'b0;
    drive(5'b00001, 3'b000);
    n_total++;
    if (result_q_o !== 1'b0)
      $display("FAIL reg_rst: got %b want 0", result_q_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++;
    if (result_q_o !== 1'b0)
      $display("FAIL reg_pre: got %b want 0", result_q_o);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (result_q_o !== 1'b1)
      $display("FAIL reg_cap1: got %b want 1", result_q_o);
    else n_pass++;
    @(negedge clk);
    drive(5'b00000, 3'b000);
    n_total++;
    if (result_q_o !== 1'b1)
      $display("FAIL reg_hold: got %b want 1", result_q_o);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (result_q_o !== 1'b0)
      $display("FAIL reg_cap0: got %b want 0", result_q_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(5'b00001, 3'b000);
    @(posedge clk); #1;
    n_total++;
    if (result_q_o !== 1'b1)
      $display("FAIL mid_pre: got %b want 1", result_q_o);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (result_q_o !== 1'b0 || result_o !== 1'b1)
      $display("FAIL mid_rst: got q=%b r=%b want q=0 r=1",
               result_q_o, result_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic exp_q;
    for (int i = 0; i < 200; i++) begin
      logic [4:0] d;
      logic [2:0] f;
      @(negedge clk);
      d = 5'($urandom);
      f = 3'($urandom_range(7, 0));
      drive(d, f);
      n_total++;
      if (result_o !== ref_result(d, f) || sel_err_o !== ref_err(f))
        $display("FAIL rnd%0d d=%b f=%b: got %b/%b want %b/%b",
                 i, d, f, result_o, sel_err_o,
                 ref_result(d, f), ref_err(f));
      else n_pass++;
      exp_q = ref_result(d, f);
      @(posedge clk); #1;
      n_total++;
      if (result_q_o !== exp_q)
        $display("FAIL rnd%0d_q: got %b want %b", i, result_q_o, exp_q);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_select_sweep();
    test_isolation();
    test_illegal();
    test_register();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
